// File: rtl/spram_ctrl.sv
// spram_ctrl: valid/ready request initiator for a registered single-port RAM, optional clear via SPRAM_CTRL_CLEAR_EN
module spram_ctrl #(
  parameter int WD = 8,
  parameter int AD = 4,
  parameter int CLEAR_VAL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AD-1:0] req_addr,
  input  logic [WD-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [WD-1:0] rsp_rdata,
  output logic [AD-1:0] rsp_addr,
  output logic          busy,
  output logic          mem_cs_n,
  output logic          mem_w_r_n,
  output logic [AD-1:0] mem_addr,
  output logic [WD-1:0] mem_din,
  input  logic [WD-1:0] mem_dout
);
  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_RUN   = 1'b1;
  logic [0:0]    state;
  logic          acc;
  logic          v0, v1;
  logic [AD-1:0] a0, a1;
  assign req_ready = state == S_RUN;
  assign acc = req_valid & req_ready;
  assign busy = (state == S_CLEAR) | v0 | v1;
`ifdef SPRAM_CTRL_CLEAR_EN
  logic [AD-1:0] cnt;
  // sweep every address once after reset, then serve requests forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else if (state == S_CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == {AD{1'b1}}) state <= S_RUN;
    end
  end
`else
  assign state = S_RUN;
`endif
  // drive the spram port: clear writes, accepted requests, or deselect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_cs_n  <= 1'b1;
      mem_w_r_n <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
`ifdef SPRAM_CTRL_CLEAR_EN
    end else if (state == S_CLEAR) begin
      mem_cs_n  <= 1'b0;
      mem_w_r_n <= 1'b1;
      mem_addr  <= cnt;
      mem_din   <= WD'(CLEAR_VAL);
`endif
    end else if (acc) begin
      mem_cs_n  <= 1'b0;
      mem_w_r_n <= req_we;
      mem_addr  <= req_addr;
      if (req_we) mem_din <= req_wdata;
    end else begin
      mem_cs_n <= 1'b1;
    end
  end
  // track reads through the spram latency and capture data two edges after accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0        <= 1'b0;
      v1        <= 1'b0;
      a0        <= '0;
      a1        <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_addr  <= '0;
    end else begin
      v0        <= acc & ~req_we;
      a0        <= req_addr;
      v1        <= v0;
      a1        <= a0;
      rsp_valid <= v1;
      if (v1) begin
        rsp_rdata <= mem_dout;
        rsp_addr  <= a1;
      end
    end
  end
endmodule

// File: tb/tb_spram_ctrl.sv
// tb_spram_ctrl: randomized self-checking bench for spram_ctrl against an in-order shadow-memory model
module tb_spram_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_ready, req_we;
  logic [3:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic [3:0] rsp_addr;
  logic       busy, mem_cs_n, mem_w_r_n;
  logic [3:0] mem_addr;
  logic [7:0] mem_din, mem_dout;
  logic [7:0] ram [16] = '{default: 8'h00};
  logic [7:0] shadow [16];
  int         qa[$], qd[$], qt[$];
  int         cyc = 0;
  int         n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  spram_ctrl #(.WD(8), .AD(4), .CLEAR_VAL(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_addr(rsp_addr),
    .busy(busy), .mem_cs_n(mem_cs_n), .mem_w_r_n(mem_w_r_n),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // registered single-port RAM the controller talks to
  always @(posedge clk) begin
    if (!mem_cs_n) begin
      if (mem_w_r_n) ram[mem_addr] <= mem_din;
      else mem_dout <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_rsp();
    if (rsp_valid) begin
      if (qa.size() == 0) chk("spurious_rsp", 1, 0);
      else begin
        chk("rsp_addr", 32'(rsp_addr), qa[0]);
        chk("rsp_rdata", 32'(rsp_rdata), qd[0]);
        chk("rsp_time", cyc, qt[0]);
        void'(qa.pop_front()); void'(qd.pop_front()); void'(qt.pop_front());
      end
    end else if (qa.size() > 0 && qt[0] <= cyc) begin
      chk("rsp_missing", 0, 1);
      void'(qa.pop_front()); void'(qd.pop_front()); void'(qt.pop_front());
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [3:0] a, input logic [7:0] d);
    logic acc;
    req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    acc = v & req_ready;
    @(posedge clk);
    cyc++;
    if (acc) begin
      if (we) shadow[a] = d;
      else begin
        qa.push_back(int'(a)); qd.push_back(int'(shadow[a])); qt.push_back(cyc + 2);
      end
    end
    #1;
    check_rsp();
  endtask

  task automatic check_reset_outputs();
    chk("rst_cs_n", mem_cs_n, 1);
    chk("rst_w_r_n", mem_w_r_n, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_din", mem_din, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_addr", rsp_addr, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic after_reset();
`ifdef SPRAM_CTRL_CLEAR_EN
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    for (int i = 0; i < 16; i++) begin
      chk("clr_ready", req_ready, 0);
      chk("clr_busy", busy, 1);
      step(1'b0, 1'b0, 4'd0, 8'd0);
      chk("clr_cs_n", mem_cs_n, 0);
      chk("clr_w_r_n", mem_w_r_n, 1);
      chk("clr_addr", mem_addr, i);
    end
`endif
    chk("ready_after_rst", req_ready, 1);
  endtask

  task automatic pulse_reset();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    qa.delete(); qd.delete(); qt.delete();
    @(negedge clk);
    rst = 1'b0;
    after_reset();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    #12;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    after_reset();
`ifdef SPRAM_CTRL_CLEAR_EN
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), 8'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
`endif
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 4'(i), 8'(8'hA0 + i));
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 4'(i), 8'd0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b1, 1'b1, 4'd5, 8'h3C);
    step(1'b1, 1'b0, 4'd5, 8'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 4'd0, 8'd0);
      if (i >= 2) begin
        chk("idle_cs_n", mem_cs_n, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        chk("idle_busy", busy, 0);
      end
    end
    step(1'b1, 1'b0, 4'd1, 8'd0);
    step(1'b1, 1'b0, 4'd2, 8'd0);
    pulse_reset();
    chk("rst_mid_rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 1'($urandom), 4'($urandom), 8'($urandom));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 4'd0, 8'd0);
    chk("drained", qa.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
